// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port: one word request at a time,
// answered on a valid/ready response channel after WAIT_CYCLES wait states.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             lat_write, lat_write_d;
    logic             lat_err, lat_err_d;
    logic [IDX_W-1:0] lat_idx, lat_idx_d;
    logic [31:0]      lat_wdata, lat_wdata_d;
    logic [3:0]       lat_be, lat_be_d;
    logic             req_ready_d, rsp_valid_d, rsp_err_d;
    logic [31:0]      rsp_rdata_d;
    logic             req_err_c, mem_we_c;

    logic [31:0] mem [DEPTH_WORDS];

    // Misaligned or beyond the last word: answered with an error, RAM untouched
    assign req_err_c = (req_addr[1:0] != 2'b00) ||
                       (req_addr[ADDR_W-1:2] >= WIDX_W'(DEPTH_WORDS));

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_write_d = lat_write;
        lat_err_d   = lat_err;
        lat_idx_d   = lat_idx;
        lat_wdata_d = lat_wdata;
        lat_be_d    = lat_be;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        mem_we_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    lat_write_d = req_write;
                    lat_err_d   = req_err_c;
                    lat_idx_d   = req_addr[IDX_W+1:2];
                    lat_wdata_d = req_wdata;
                    lat_be_d    = req_be;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // Commit edge: the access happens on the edge that enters RESP
                if (cnt == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = lat_err;
                    rsp_rdata_d = (lat_write || lat_err) ? 32'h0 : mem[lat_idx];
                    mem_we_c    = rst_n && lat_write && !lat_err;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_write <= lat_write_d;
            lat_err   <= lat_err_d;
            lat_idx   <= lat_idx_d;
            lat_wdata <= lat_wdata_d;
            lat_be    <= lat_be_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Word RAM, byte-masked write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the main
// flows and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        r0_req_valid, r0_req_ready, r0_req_write, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
    logic [3:0]  r0_req_be;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_write(r0_req_write),
        .req_addr(r0_req_addr), .req_wdata(r0_req_wdata), .req_be(r0_req_be),
        .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready), .rsp_rdata(r0_rsp_rdata),
        .rsp_err(r0_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one request from #1 after an edge; returns once rsp_valid is seen.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'h0000_0014;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [8:0]  rdy_seen, vld_seen;
    logic [31:0] rd_seen [9];

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        rsp_ready = 1'b1;
        r0_req_valid = 1'b0; r0_req_write = 1'b0; r0_req_addr = 32'h0; r0_req_wdata = 32'h0;
        r0_req_be = 4'h0; r0_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word store then load
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        check("st10_latency", 32'(lat), 32'd3);
        check("st10_err",     32'(rsp_err), 32'd0);
        check("st10_rdata",   rsp_rdata, 32'h0);
        check("st10_req_ready_busy", 32'(req_ready), 32'd0);
        finish_rsp();
        check("st10_back_idle", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        check("ld10_latency", 32'(lat), 32'd3);
        check("ld10_rdata",   rsp_rdata, 32'hDEADBEEF);
        check("ld10_err",     32'(rsp_err), 32'd0);
        finish_rsp();

        // Byte-masked store merges into the existing word
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, lat);
        finish_rsp();
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat);
        check("st20_be_err", 32'(rsp_err), 32'd0);
        finish_rsp();
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat);
        check("st20_be0_err", 32'(rsp_err), 32'd0);
        finish_rsp();
        issue(1'b0, 32'h20, 32'h0, 4'h0, lat);
        check("ld20_merged", rsp_rdata, 32'h11BB33DD);
        finish_rsp();

        // Misaligned and out-of-range requests
        issue(1'b0, 32'h22, 32'h0, 4'hF, lat);
        check("ld22_err",     32'(rsp_err), 32'd1);
        check("ld22_rdata",   rsp_rdata, 32'h0);
        check("ld22_latency", 32'(lat), 32'd3);
        finish_rsp();
        issue(1'b0, 32'h400, 32'h0, 4'hF, lat);
        check("ld400_err",   32'(rsp_err), 32'd1);
        check("ld400_rdata", rsp_rdata, 32'h0);
        finish_rsp();
        issue(1'b1, 32'h410, 32'h12345678, 4'hF, lat);
        check("st410_err", 32'(rsp_err), 32'd1);
        finish_rsp();
        issue(1'b1, 32'h11, 32'h0, 4'hF, lat);
        check("st11_err", 32'(rsp_err), 32'd1);
        finish_rsp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        check("ld10_unchanged", rsp_rdata, 32'hDEADBEEF);
        check("ld10_unchanged_err", 32'(rsp_err), 32'd0);
        finish_rsp();

        // Response back-pressure
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_rsp_valid", 32'(rsp_valid), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'd1);

        // Reset on the commit edge of a store drops it
        issue(1'b1, 32'h30, 32'h0, 4'hF, lat);
        finish_rsp();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        issue(1'b0, 32'h30, 32'h0, 4'h0, lat);
        check("ld30_not_committed", rsp_rdata, 32'h0);
        finish_rsp();

        // Zero wait states, request held valid: store then two loads
        r0_req_valid = 1'b1; r0_req_write = 1'b1; r0_req_addr = 32'h0;
        r0_req_wdata = 32'h0BADF00D; r0_req_be = 4'hF;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rdy_seen[c] = r0_req_ready;
            vld_seen[c] = r0_rsp_valid;
            rd_seen[c]  = r0_rsp_rdata;
            @(posedge clk); #1;
            if (c == 0) r0_req_write = 1'b0;
        end
        r0_req_valid = 1'b0;
        check("w0_ready_pattern", 32'(rdy_seen), 32'(9'b001001001));
        check("w0_valid_pattern", 32'(vld_seen), 32'(9'b100100100));
        check("w0_store_rdata", rd_seen[2], 32'h0);
        check("w0_load1_rdata", rd_seen[5], 32'h0BADF00D);
        check("w0_load2_rdata", rd_seen[8], 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
